uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmitter between N_REQ byte producers (e.g. CPU console port, debug/trace unit, boot monitor).
- Sits between the requesters and the UART tx_data/tx_data_vld/tx_active interface.
- Sequences one byte at a time: it launches the byte, waits for the transmitter to go busy, then waits for it to go idle.
- Supports locked bursts so a requester can send a multi-byte message without other requesters' bytes interleaving.

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// One byte in flight at a time; locked requesters may send back-to-back bursts up to MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = 8,
    parameter int START_TMO = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           lock_i,
    input  logic [N_REQ*DATA_BITS-1:0] data_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [DATA_BITS-1:0]       tx_data_o,
    output logic                       tx_data_vld_o,
    input  logic                       tx_active_i,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic                       busy_o,
    output logic                       tmo_err_o
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int TMO_W   = $clog2(START_TMO + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_LAUNCH     = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

    logic [1:0]           state_reg, state_next;
    logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]     owner_reg, owner_next;
    logic [BURST_W-1:0]   burst_cnt_reg, burst_cnt_next;
    logic [TMO_W-1:0]     tmo_cnt_reg, tmo_cnt_next;
    logic [DATA_BITS-1:0] tx_data_reg, tx_data_next;
    logic [N_REQ-1:0]     gnt_reg, gnt_next;
    logic                 vld_reg, vld_next;
    logic                 tmo_err_reg, tmo_err_next;

    logic [DATA_BITS-1:0] data_arr [N_REQ];
    logic [PTR_W-1:0]     cand [N_REQ];
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    logic [PTR_W-1:0]     ptr_after_owner;

    // cand[gi] is the requester index examined gi places after the round-robin pointer.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        logic [PTR_W:0] sum;
        assign data_arr[gi] = data_i[gi*DATA_BITS +: DATA_BITS];
        assign sum          = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
        assign cand[gi]     = (sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                                                         : PTR_W'(sum);
    end

    // Scan from the far end so the candidate closest to the pointer is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[cand[i]]) begin
                win_found = 1'b1;
                win_idx   = cand[i];
            end
        end
    end

    assign ptr_after_owner = (owner_reg == PTR_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        tx_data_next   = tx_data_reg;
        gnt_next       = '0;
        vld_next       = 1'b0;
        tmo_err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!tx_active_i && win_found) begin
                    owner_next     = win_idx;
                    tx_data_next   = data_arr[win_idx];
                    burst_cnt_next = lock_i[win_idx] ? BURST_W'(1) : '0;
                    gnt_next       = N_REQ'(1) << win_idx;
                    vld_next       = 1'b1;
                    state_next     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                rr_ptr_next  = ptr_after_owner;
                tmo_cnt_next = '0;
                state_next   = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (tx_active_i) begin
                    state_next = ST_WAIT_DONE;
                end else if (tmo_cnt_reg == TMO_W'(START_TMO - 1)) begin
                    // Byte was already granted, so it is dropped rather than retried.
                    tmo_err_next   = 1'b1;
                    burst_cnt_next = '0;
                    state_next     = ST_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_active_i) begin
                    if (lock_i[owner_reg] && req_i[owner_reg] &&
                        (burst_cnt_reg < BURST_W'(MAX_BURST))) begin
                        tx_data_next   = data_arr[owner_reg];
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                        gnt_next       = N_REQ'(1) << owner_reg;
                        vld_next       = 1'b1;
                        state_next     = ST_LAUNCH;
                    end else begin
                        burst_cnt_next = '0;
                        state_next     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            tx_data_reg   <= '0;
            gnt_reg       <= '0;
            vld_reg       <= 1'b0;
            tmo_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            tx_data_reg   <= tx_data_next;
            gnt_reg       <= gnt_next;
            vld_reg       <= vld_next;
            tmo_err_reg   <= tmo_err_next;
        end
    end

    assign gnt_o         = gnt_reg;
    assign tx_data_vld_o = vld_reg;
    assign tx_data_o     = tx_data_reg;
    assign owner_o       = owner_reg;
    assign busy_o        = (state_reg != ST_IDLE);
    assign tmo_err_o     = tmo_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester scenarios push expected (owner, byte) pairs,
// a monitor pops and compares on every launch strobe.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_i;
    logic [N-1:0]      lock_i;
    logic [N*DB-1:0]   data_i;
    logic [N-1:0]      gnt_o;
    logic [DB-1:0]     tx_data_o;
    logic              tx_data_vld_o;
    logic              tx_active_i;
    logic [1:0]        owner_o;
    logic              busy_o;
    logic              tmo_err_o;

    uart_tx_arbiter #(
        .N_REQ(N), .DATA_BITS(DB), .START_TMO(4), .MAX_BURST(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i), .data_i(data_i),
        .gnt_o(gnt_o), .tx_data_o(tx_data_o), .tx_data_vld_o(tx_data_vld_o),
        .tx_active_i(tx_active_i), .owner_o(owner_o), .busy_o(busy_o), .tmo_err_o(tmo_err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct packed {
        logic [1:0] owner;
        logic [7:0] data;
        logic       gap;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int o, input int d, input bit g);
        exp_t e;
        e.owner = 2'(o);
        e.data  = 8'(d);
        e.gap   = g;
        sb.push_back(e);
    endtask

    // Requester byte queues: main thread appends at tail, driver advances head after each grant.
    logic [7:0] rq_data [N][64];
    int         rq_head [N];
    int         rq_tail [N];
    bit         rq_lock [N];
    int         flush_req = 0;

    task automatic enq(input int k, input int d);
        rq_data[k][rq_tail[k]] = 8'(d);
        rq_tail[k]++;
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) if (rq_head[k] < rq_tail[k]) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [N-1:0] gnt_prev;
        int           flush_ack;
        gnt_prev  = '0;
        flush_ack = 0;
        req_i     = '0;
        lock_i    = '0;
        data_i    = '0;
        forever begin
            @(posedge clk_i);
            #1;
            for (int k = 0; k < N; k++)
                if (gnt_prev[k] && rq_head[k] < rq_tail[k]) rq_head[k]++;
            if (flush_ack != flush_req) begin
                for (int k = 0; k < N; k++) rq_head[k] = rq_tail[k];
                flush_ack = flush_req;
            end
            gnt_prev = gnt_o;
            for (int k = 0; k < N; k++) begin
                bit has;
                has                = rq_head[k] < rq_tail[k];
                req_i[k]           = has;
                lock_i[k]          = has && rq_lock[k];
                data_i[k*DB +: DB] = has ? rq_data[k][rq_head[k]] : 8'h00;
            end
        end
    end

    // UART model: busy for 10 cycles starting the cycle after a launch strobe.
    bit uart_en = 1'b1;
    initial begin
        int   uart_cnt;
        logic vld_seen;
        uart_cnt    = 0;
        vld_seen    = 1'b0;
        tx_active_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (vld_seen && uart_en) uart_cnt = 10;
            else if (uart_cnt > 0)   uart_cnt--;
            vld_seen    = tx_data_vld_o;
            tx_active_i = (uart_cnt > 0);
        end
    end

    int tmo_seen = 0;
    initial begin
        logic prev_act;
        int   fall_cyc;
        exp_t e;
        prev_act = 1'b0;
        fall_cyc = -100;
        forever begin
            @(negedge clk_i);
            if (prev_act && !tx_active_i) fall_cyc = cyc;
            prev_act = tx_active_i;
            if (tmo_err_o === 1'b1) tmo_seen++;
            if (gnt_o !== '0 && tx_data_vld_o !== 1'b1) chk("gnt_without_strobe", 32'(gnt_o), 0);
            if (tx_data_vld_o === 1'b1) begin
                $display("strobe cyc=%0d owner=%0d data=%02h gnt=%b", cyc, owner_o, tx_data_o, gnt_o);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("gnt", 32'(gnt_o), 32'(1) << e.owner);
                    chk("tx_data", 32'(tx_data_o), 32'(e.data));
                    chk("owner", 32'(owner_o), 32'(e.owner));
                    chk("vld_while_active", 32'(tx_active_i), 0);
                    if (e.gap) chk("burst_gap", 32'(cyc - fall_cyc), 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_strobe(output int c);
        int i;
        c = -1;
        i = 0;
        while (c < 0 && i < 300) begin
            @(negedge clk_i);
            if (tx_data_vld_o === 1'b1) c = cyc;
            i++;
        end
        if (c < 0) chk("strobe_timeout", 0, 1);
    endtask

    task automatic wait_active(input logic lvl);
        int i;
        i = 0;
        @(negedge clk_i);
        while (tx_active_i !== lvl && i < 300) begin
            @(negedge clk_i);
            i++;
        end
        if (i >= 300) chk("active_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        tick(1);
        while (i < 3000 && (busy_o || tx_active_i || sb.size() != 0 || pending())) begin
            tick(1);
            i++;
        end
        if (i >= 3000) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        flush_req++;
        tick(2);
        rst_i = 1'b0;
        tick(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt_o), 0);
        chk({tag, "_vld"}, 32'(tx_data_vld_o), 0);
        chk({tag, "_data"}, 32'(tx_data_o), 0);
        chk({tag, "_owner"}, 32'(owner_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_tmo"}, 32'(tmo_err_o), 0);
    endtask

    initial begin
        int rc, sc, tc, i;
        rst_i = 1'b1;
        tick(3);
        chk_reset_outputs("reset");
        rst_i = 1'b0;
        tick(1);

        // Single byte; latency counted inclusively from the cycle req is first presented.
        push(2, 'hA5, 0);
        enq(2, 'hA5);
        rc = -1;
        i  = 0;
        while (rc < 0 && i < 20) begin
            @(negedge clk_i);
            if (req_i[2]) rc = cyc;
            i++;
        end
        wait_strobe(sc);
        chk("latency", 32'(sc - rc + 1), 2);
        wait_active(1'b1);
        wait_active(1'b0);
        chk("busy_at_fall", 32'(busy_o), 1);
        tick(1);
        chk("busy_after_fall", 32'(busy_o), 0);
        wait_idle();
        do_reset();

        // All four requesting, no lock: 0,1,2,3,0.
        push(0, 'hB0, 0); push(1, 'hB1, 0); push(2, 'hB2, 0); push(3, 'hB3, 0); push(0, 'hB4, 0);
        enq(0, 'hB0); enq(0, 'hB4); enq(1, 'hB1); enq(2, 'hB2); enq(3, 'hB3);
        wait_idle();
        do_reset();

        // Locked burst from 1 while 0 and 3 wait: 11,22,33 then 3 then 0.
        rq_lock[1] = 1'b1;
        push(1, 'h11, 0); push(1, 'h22, 1); push(1, 'h33, 1); push(3, 'h3A, 0); push(0, 'h0A, 0);
        enq(1, 'h11); enq(1, 'h22); enq(1, 'h33);
        tick(2);
        enq(0, 'h0A); enq(3, 'h3A);
        wait_idle();
        rq_lock[1] = 1'b0;
        do_reset();

        // Endless locked stream from 2: 16 bytes, then 3, then 2 resumes.
        rq_lock[2] = 1'b1;
        for (int k = 0; k < 16; k++) push(2, 'h80 + k, k > 0);
        push(3, 'h3F, 0);
        for (int k = 16; k < 20; k++) push(2, 'h80 + k, k > 16);
        for (int k = 0; k < 20; k++) enq(2, 'h80 + k);
        enq(3, 'h3F);
        wait_idle();
        rq_lock[2] = 1'b0;
        do_reset();

        // Transmitter never goes busy: timeout 4 cycles after entering WAIT_START.
        uart_en = 1'b0;
        push(1, 'h55, 0);
        enq(1, 'h55);
        wait_strobe(sc);
        tc = -1;
        i  = 0;
        while (tc < 0 && i < 20) begin
            @(negedge clk_i);
            if (tmo_err_o === 1'b1) tc = cyc;
            i++;
        end
        if (tc < 0) chk("tmo_timeout", 0, 1);
        else begin
            chk("tmo_delay", 32'(tc - sc), 5);
            chk("tmo_idle", 32'(busy_o), 0);
        end
        uart_en = 1'b1;
        push(2, 'h66, 0);
        enq(2, 'h66);
        wait_idle();

        // Reset in WAIT_DONE with a locked burst pending; pointer must restart at 0.
        rq_lock[1] = 1'b1;
        push(1, 'hC1, 0);
        enq(1, 'hC1); enq(1, 'hC2); enq(1, 'hC3);
        wait_strobe(sc);
        wait_active(1'b1);
        tick(3);
        rst_i      = 1'b1;
        rq_lock[1] = 1'b0;
        flush_req++;
        tick(1);
        chk_reset_outputs("midrst");
        tick(1);
        rst_i = 1'b0;
        push(0, 'hD0, 0); push(3, 'hD3, 0);
        enq(0, 'hD0); enq(3, 'hD3);
        wait_idle();

        chk("sb_empty", 32'(sb.size()), 0);
        chk("tmo_pulses", 32'(tmo_seen), 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
